// File: rtl/asynchronous_fifo_package.sv
// -----------------------------------------------------------------------------
// asynchronous_fifo_package
// Pointer-coding helpers shared by the write and read controllers of the
// asynchronous FIFO.
//   bin_to_gray : binary -> reflected Gray code
//   gray_to_bin : reflected Gray code -> binary (bit i = XOR of bits >= i)
// Both functions work on PTR_MAX_WIDTH-bit words. Callers zero-extend their
// PW-bit pointers and keep the low PW bits of the result. PW must stay below
// PTR_MAX_WIDTH.
// -----------------------------------------------------------------------------
package asynchronous_fifo_package;

  localparam int PTR_MAX_WIDTH = 32;

  function automatic logic [PTR_MAX_WIDTH-1:0] bin_to_gray(input logic [PTR_MAX_WIDTH-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [PTR_MAX_WIDTH-1:0] gray_to_bin(input logic [PTR_MAX_WIDTH-1:0] gray);
    logic [PTR_MAX_WIDTH-1:0] bin;
    bin = '0;
    for (int i = 0; i < PTR_MAX_WIDTH; i++) begin
      bin[i] = ^(gray >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/asynchronous_fifo_write_controller_if.sv
// -----------------------------------------------------------------------------
// asynchronous_fifo_write_controller_if
// Groups the write controller's producer, memory and cross-domain signals.
//   master : producer / environment side (drives write request, clear and the
//            raw read-domain Gray pointer; observes everything else)
//   slave  : the write controller itself
// -----------------------------------------------------------------------------
interface asynchronous_fifo_write_controller_if #(
  parameter int DATA_WIDTH = 16,
  parameter int PW         = 12
);
  logic                  write_enable;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  clear_overflow;
  logic [PW-1:0]         read_pointer_gray;
  logic                  memory_write_enable;
  logic [PW-1:0]         memory_write_address;
  logic [DATA_WIDTH-1:0] memory_write_data;
  logic [PW-1:0]         write_pointer_gray;
  logic                  full;
  logic                  almost_full;
  logic [PW-1:0]         fill_level;
  logic                  overflow;

  modport master (
    output write_enable, write_data, clear_overflow, read_pointer_gray,
    input  memory_write_enable, memory_write_address, memory_write_data,
    input  write_pointer_gray, full, almost_full, fill_level, overflow
  );

  modport slave (
    input  write_enable, write_data, clear_overflow, read_pointer_gray,
    output memory_write_enable, memory_write_address, memory_write_data,
    output write_pointer_gray, full, almost_full, fill_level, overflow
  );
endinterface

// File: rtl/asynchronous_fifo_gray_synchronizer.sv
// -----------------------------------------------------------------------------
// asynchronous_fifo_gray_synchronizer
// Two-flop synchronizer for a Gray-coded pointer coming from the other clock
// domain. Only one bit changes per pointer step, so a metastable capture
// resolves to either the old or the new pointer value.
//   clock    : destination-domain clock
//   reset_n  : asynchronous active-low reset, clears both stages
//   async_in : Gray pointer from the foreign domain
//   sync_out : synchronized pointer (2 clocks of latency)
// -----------------------------------------------------------------------------
module asynchronous_fifo_gray_synchronizer #(
  parameter int WIDTH = 12
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);

  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sync_0_q;
  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sync_1_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_0_q <= '0;
      sync_1_q <= '0;
    end else begin
      sync_0_q <= async_in;
      sync_1_q <= sync_0_q;
    end
  end

  assign sync_out = sync_1_q;

endmodule

// File: rtl/asynchronous_fifo_write_controller.sv
// -----------------------------------------------------------------------------
// asynchronous_fifo_write_controller
// Write-domain half of the asynchronous FIFO. Accepts producer words, drives
// the memory write port, publishes a registered Gray write pointer and derives
// full / almost_full / fill_level / sticky overflow against the synchronized
// read pointer. Capacity is DATA_DEPTH-1: equal pointers always mean empty.
//   clock, reset_n : write-domain clock, asynchronous active-low reset
//   bus (slave)    : write_enable, write_data, clear_overflow,
//                    read_pointer_gray (unsynchronized) in;
//                    memory_write_enable/address/data (combinational),
//                    write_pointer_gray, full, almost_full, fill_level,
//                    overflow (registered) out
// -----------------------------------------------------------------------------
module asynchronous_fifo_write_controller
  import asynchronous_fifo_package::*;
#(
  parameter int DATA_WIDTH         = 16,
  parameter int DATA_DEPTH         = 4096,
  parameter int ALMOST_FULL_MARGIN = 4
) (
  input logic                                clock,
  input logic                                reset_n,
  asynchronous_fifo_write_controller_if.slave bus
);

  localparam int PW = $clog2(DATA_DEPTH);
  localparam logic [PW-1:0] LAST_SLOT = PW'(DATA_DEPTH - 1);
  localparam logic [PW-1:0] MARGIN    = PW'(ALMOST_FULL_MARGIN);

  logic [PW-1:0] write_pointer_q,      write_pointer_d;
  logic [PW-1:0] write_pointer_gray_q, write_pointer_gray_d;
  logic [PW-1:0] fill_level_q,         fill_level_d;
  logic          full_q,               full_d;
  logic          almost_full_q,        almost_full_d;
  logic          overflow_q,           overflow_d;

  logic [PW-1:0]              read_pointer_gray_sync;
  logic [PW-1:0]              rp_bin;
  logic [PTR_MAX_WIDTH-1:0]   gray_wide;
  logic [PTR_MAX_WIDTH-1:0]   rp_wide;
  logic                       accept;
  logic                       unused_wide_bits;

  asynchronous_fifo_gray_synchronizer #(
    .WIDTH (PW)
  ) u_read_pointer_sync (
    .clock    (clock),
    .reset_n  (reset_n),
    .async_in (bus.read_pointer_gray),
    .sync_out (read_pointer_gray_sync)
  );

  // Helpers operate on full-width words; only the low PW bits are meaningful.
  assign rp_wide          = gray_to_bin({{(PTR_MAX_WIDTH-PW){1'b0}}, read_pointer_gray_sync});
  assign rp_bin           = rp_wide[PW-1:0];
  assign gray_wide        = bin_to_gray({{(PTR_MAX_WIDTH-PW){1'b0}}, write_pointer_d});
  assign unused_wide_bits = ^{gray_wide[PTR_MAX_WIDTH-1:PW], rp_wide[PTR_MAX_WIDTH-1:PW]};

  always_comb begin
    accept               = bus.write_enable && !full_q;
    write_pointer_d      = write_pointer_q + {{(PW-1){1'b0}}, accept};
    write_pointer_gray_d = gray_wide[PW-1:0];
    // Flags use the post-write pointer so they never lag a write; the read
    // pointer only moves forward, so a stale rp_bin can only overstate fill.
    fill_level_d         = write_pointer_d - rp_bin;
    full_d               = (write_pointer_d + PW'(1)) == rp_bin;
    almost_full_d        = (LAST_SLOT - fill_level_d) <= MARGIN;
    // A dropped write sets the flag even if a clear arrives in the same cycle.
    if (bus.write_enable && full_q) begin
      overflow_d = 1'b1;
    end else if (bus.clear_overflow) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      write_pointer_q      <= '0;
      write_pointer_gray_q <= '0;
      fill_level_q         <= '0;
      full_q               <= 1'b0;
      almost_full_q        <= 1'b0;
      overflow_q           <= 1'b0;
    end else begin
      write_pointer_q      <= write_pointer_d;
      write_pointer_gray_q <= write_pointer_gray_d;
      fill_level_q         <= fill_level_d;
      full_q               <= full_d;
      almost_full_q        <= almost_full_d;
      overflow_q           <= overflow_d;
    end
  end

  assign bus.memory_write_enable  = accept;
  assign bus.memory_write_address = write_pointer_q;
  assign bus.memory_write_data    = bus.write_data;
  assign bus.write_pointer_gray   = write_pointer_gray_q;
  assign bus.full                 = full_q;
  assign bus.almost_full          = almost_full_q;
  assign bus.fill_level           = fill_level_q;
  assign bus.overflow             = overflow_q;

endmodule

// File: tb/tb_asynchronous_fifo_write_controller.sv
// -----------------------------------------------------------------------------
// tb_asynchronous_fifo_write_controller
// Directed scenarios plus a randomized run against a word-count model of the
// write controller (DATA_DEPTH=8, ALMOST_FULL_MARGIN=2, DATA_WIDTH=16).
// -----------------------------------------------------------------------------
module tb_asynchronous_fifo_write_controller;

  localparam int DW     = 16;
  localparam int DEPTH  = 8;
  localparam int MARGIN = 2;
  localparam int PW     = 3;

  logic clock;
  logic reset_n;
  int   tests_run;
  int   tests_failed;

  asynchronous_fifo_write_controller_if #(.DATA_WIDTH(DW), .PW(PW)) bus ();

  asynchronous_fifo_write_controller #(
    .DATA_WIDTH         (DW),
    .DATA_DEPTH         (DEPTH),
    .ALMOST_FULL_MARGIN (MARGIN)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Returns just after the next rising edge, where registered outputs are stable.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [PW-1:0] gray_of(input int unsigned v);
    int unsigned m;
    m = v % DEPTH;
    return PW'(m ^ (m >> 1));
  endfunction

  task automatic idle_inputs();
    bus.write_enable      = 1'b0;
    bus.write_data        = '0;
    bus.clear_overflow    = 1'b0;
    bus.read_pointer_gray = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle_inputs();
    #1;
    tests_run++;
    if ({bus.full, bus.almost_full, bus.overflow} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_flags: full/af/ovf=%b required 000", {bus.full, bus.almost_full, bus.overflow});
    end
    tests_run++;
    if ({bus.fill_level, bus.write_pointer_gray} !== 6'd0) begin
      tests_failed++;
      $display("FAIL reset_pointers: fill=%0d gray=%b required 0/000", bus.fill_level, bus.write_pointer_gray);
    end
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_fill();
    logic [PW-1:0] gray_seq [7];
    gray_seq = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
    for (int i = 0; i < 7; i++) begin
      bus.write_enable = 1'b1;
      bus.write_data   = DW'(16'hA0 + i);
      #1;
      $display("[TB] fill write addr=%0d data=%h we=%b", bus.memory_write_address, bus.memory_write_data, bus.memory_write_enable);
      tests_run++;
      if (bus.memory_write_enable !== 1'b1 || bus.memory_write_address !== PW'(i) ||
          bus.memory_write_data !== DW'(16'hA0 + i)) begin
        tests_failed++;
        $display("FAIL fill_mem[%0d]: we=%b addr=%0d data=%h required 1/%0d/%h", i,
                 bus.memory_write_enable, bus.memory_write_address, bus.memory_write_data, i, 16'hA0 + i);
      end
      tick();
      tests_run++;
      if (bus.write_pointer_gray !== gray_seq[i] || bus.almost_full !== (i >= 4) || bus.full !== (i == 6)) begin
        tests_failed++;
        $display("FAIL fill_state[%0d]: gray=%b af=%b full=%b required %b/%b/%b", i,
                 bus.write_pointer_gray, bus.almost_full, bus.full, gray_seq[i], i >= 4, i == 6);
      end
    end
    bus.write_enable = 1'b0;
    tests_run++;
    if (bus.fill_level !== 3'd7) begin
      tests_failed++;
      $display("FAIL fill_level_full: got %0d required 7", bus.fill_level);
    end
  endtask

  task automatic test_overflow();
    bus.write_enable = 1'b1;
    bus.write_data   = 16'hA7;
    #1;
    tests_run++;
    if (bus.memory_write_enable !== 1'b0) begin
      tests_failed++;
      $display("FAIL overflow_drop: memory_write_enable=%b required 0", bus.memory_write_enable);
    end
    tick();
    bus.write_enable = 1'b0;
    tests_run++;
    if (bus.write_pointer_gray !== 3'b100 || bus.overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL overflow_set: gray=%b ovf=%b required 100/1", bus.write_pointer_gray, bus.overflow);
    end
    tick(); tick(); tick();
    tests_run++;
    if (bus.overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL overflow_hold: got %b required 1", bus.overflow);
    end
    bus.clear_overflow = 1'b1;
    tick();
    bus.clear_overflow = 1'b0;
    tests_run++;
    if (bus.overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL overflow_clear: got %b required 0", bus.overflow);
    end
  endtask

  task automatic test_simultaneous();
    bus.write_enable   = 1'b1;
    bus.write_data     = 16'hBB;
    bus.clear_overflow = 1'b1;
    tick();
    bus.write_enable = 1'b0;
    tests_run++;
    if (bus.overflow !== 1'b1 || bus.write_pointer_gray !== 3'b100) begin
      tests_failed++;
      $display("FAIL set_beats_clear: ovf=%b gray=%b required 1/100", bus.overflow, bus.write_pointer_gray);
    end
    tick();
    bus.clear_overflow = 1'b0;
    tests_run++;
    if (bus.overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL clear_after_set: got %b required 0", bus.overflow);
    end
  endtask

  task automatic test_drain_wrap();
    logic [PW-1:0] addr_seq [5];
    logic [PW-1:0] gray_seq [5];
    addr_seq = '{3'd7, 3'd0, 3'd1, 3'd2, 3'd3};
    gray_seq = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110};
    bus.read_pointer_gray = 3'b111;   // read pointer 5
    tick();
    tick();
    tests_run++;
    if (bus.full !== 1'b1) begin
      tests_failed++;
      $display("FAIL drain_early: full=%b after 2 clocks required 1", bus.full);
    end
    tick();
    tests_run++;
    if (bus.full !== 1'b0 || bus.fill_level !== 3'd2 || bus.almost_full !== 1'b0) begin
      tests_failed++;
      $display("FAIL drain_visible: full=%b fill=%0d af=%b required 0/2/0", bus.full, bus.fill_level, bus.almost_full);
    end
    for (int i = 0; i < 5; i++) begin
      bus.write_enable = 1'b1;
      bus.write_data   = DW'(16'hC0 + i);
      #1;
      $display("[TB] wrap write addr=%0d data=%h", bus.memory_write_address, bus.memory_write_data);
      tests_run++;
      if (bus.memory_write_enable !== 1'b1 || bus.memory_write_address !== addr_seq[i]) begin
        tests_failed++;
        $display("FAIL wrap_addr[%0d]: we=%b addr=%0d required 1/%0d", i, bus.memory_write_enable,
                 bus.memory_write_address, addr_seq[i]);
      end
      tick();
      // fill rises from 2; full only when 7 words are held.
      tests_run++;
      if (bus.write_pointer_gray !== gray_seq[i] || bus.fill_level !== PW'(3 + i) ||
          bus.full !== (i == 4) || bus.almost_full !== (i >= 2)) begin
        tests_failed++;
        $display("FAIL wrap_state[%0d]: gray=%b fill=%0d full=%b af=%b required %b/%0d/%b/%b", i,
                 bus.write_pointer_gray, bus.fill_level, bus.full, bus.almost_full,
                 gray_seq[i], 3 + i, i == 4, i >= 2);
      end
    end
    bus.write_enable = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.write_enable = 1'b1;
      bus.write_data   = DW'(16'hD0 + i);
      tick();
    end
    #3;
    reset_n = 1'b0;
    bus.write_enable = 1'b0;
    #1;
    tests_run++;
    if (bus.write_pointer_gray !== 3'b000 || bus.fill_level !== 3'd0 || bus.full !== 1'b0) begin
      tests_failed++;
      $display("FAIL midburst_reset: gray=%b fill=%0d full=%b required 000/0/0",
               bus.write_pointer_gray, bus.fill_level, bus.full);
    end
    tick();
    reset_n = 1'b1;
    bus.write_enable = 1'b1;
    bus.write_data   = 16'h55;
    #1;
    tests_run++;
    if (bus.memory_write_enable !== 1'b1 || bus.memory_write_address !== 3'd0) begin
      tests_failed++;
      $display("FAIL midburst_first_addr: we=%b addr=%0d required 1/0", bus.memory_write_enable, bus.memory_write_address);
    end
    tick();
    bus.write_enable = 1'b0;
  endtask

  // Model: count of accepted words vs. count of words read, with the read
  // count seen by the write domain two clocks late.
  task automatic test_random();
    int unsigned wr_count;
    int unsigned rd_count;
    int unsigned rp_hist[$];
    int unsigned rp_vis;
    int unsigned held;
    logic        exp_full;
    logic        exp_ovf;
    logic        we;
    logic        clr;
    logic [DW-1:0] data;
    logic        exp_accept;
    do_reset();
    wr_count = 0;
    rd_count = 0;
    exp_full = 1'b0;
    exp_ovf  = 1'b0;
    rp_hist.push_back(0);
    rp_hist.push_back(0);
    for (int cyc = 0; cyc < 300; cyc++) begin
      we   = ($urandom_range(0, 3) != 0);
      clr  = ($urandom_range(0, 7) == 0);
      data = DW'($urandom);
      if (rd_count < wr_count && $urandom_range(0, 2) == 0) rd_count++;
      bus.write_enable      = we;
      bus.write_data        = data;
      bus.clear_overflow    = clr;
      bus.read_pointer_gray = gray_of(rd_count);
      rp_hist.push_back(rd_count);
      exp_accept = we && !exp_full;
      #1;
      tests_run++;
      if (bus.memory_write_enable !== exp_accept ||
          (exp_accept && (bus.memory_write_address !== PW'(wr_count % DEPTH) || bus.memory_write_data !== data))) begin
        tests_failed++;
        $display("FAIL rand_mem[%0d]: we=%b addr=%0d data=%h required %b/%0d/%h", cyc,
                 bus.memory_write_enable, bus.memory_write_address, bus.memory_write_data,
                 exp_accept, wr_count % DEPTH, data);
      end
      if (exp_accept) begin
        $display("[TB] rand write cyc=%0d addr=%0d data=%h", cyc, wr_count % DEPTH, data);
      end
      tick();
      if (exp_accept) wr_count++;
      if (we && exp_full) exp_ovf = 1'b1;
      else if (clr)      exp_ovf = 1'b0;
      rp_vis   = rp_hist[rp_hist.size() - 3];
      held     = wr_count - rp_vis;
      exp_full = (held == DEPTH - 1);
      tests_run++;
      if (bus.full !== exp_full || bus.almost_full !== ((DEPTH - 1 - held) <= MARGIN) ||
          bus.fill_level !== PW'(held) || bus.overflow !== exp_ovf ||
          bus.write_pointer_gray !== gray_of(wr_count)) begin
        tests_failed++;
        $display("FAIL rand_state[%0d]: full=%b af=%b fill=%0d ovf=%b gray=%b required %b/%b/%0d/%b/%b", cyc,
                 bus.full, bus.almost_full, bus.fill_level, bus.overflow, bus.write_pointer_gray,
                 exp_full, (DEPTH - 1 - held) <= MARGIN, held, exp_ovf, gray_of(wr_count));
      end
    end
    idle_inputs();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_fill();
    test_overflow();
    test_simultaneous();
    test_drain_wrap();
    test_reset_mid_burst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
